// File: rtl/request_unit_pkg.sv
// Shared types for the memory request unit: word bus type, FSM state and the
// registered data-request payload.
package request_unit_pkg;

  localparam int unsigned WORD_W                 = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

  typedef struct packed {
    word_t addr;
    word_t data;
    logic  ren;
    logic  wen;
  } dreq_t;

  // Effective address forced onto a word boundary.
  function automatic word_t word_align(word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/request_unit_if.sv
// Signal bundle between the request unit, the datapath/control unit and the
// memory controller.
interface request_unit_if;
  import request_unit_pkg::*;

  logic  ihit;
  logic  dhit;
  logic  dREN_ctrl;
  logic  dWEN_ctrl;
  logic  halt_ctrl;
  word_t alu_result;
  word_t store_data;
  logic  imemREN;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  pc_en;
  logic  halt;
  word_t instr_count;
  logic  timeout_err;

  modport master (
    input  ihit, dhit, dREN_ctrl, dWEN_ctrl, halt_ctrl, alu_result, store_data,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halt,
           instr_count, timeout_err
  );

  // Whole environment seen from outside the request unit.
  modport slave (
    output ihit, dhit, dREN_ctrl, dWEN_ctrl, halt_ctrl, alu_result, store_data,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, halt,
           instr_count, timeout_err
  );

  modport datapath (
    output dREN_ctrl, dWEN_ctrl, halt_ctrl, alu_result, store_data,
    input  pc_en, halt, instr_count, timeout_err
  );

  modport memctl (
    output ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore
  );

endinterface

// File: rtl/req_watchdog.sv
// Data-request watchdog: counts DATA cycles without dhit and flags the cycle
// in which the LIMIT-th such cycle occurs. Used only under REQUEST_TIMEOUT_EN.
module req_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic dhit,
  output logic expire_c
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;

  // A dhit in the limit cycle suppresses expiry so the access retires.
  assign expire_c = active && !dhit && (count_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (active && !dhit && !expire_c) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory request unit: registers load/store requests from the ALU result,
// gates PC advance, tracks halt and counts retired instructions.
// Optional data-request timeout enabled by defining REQUEST_TIMEOUT_EN.
module request_unit
  import request_unit_pkg::*;
`ifdef REQUEST_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT)
`endif
(
  input logic            CLK,
  input logic            RST,
  request_unit_if.master bus
);

  reqstate_t state, state_next;
  dreq_t     req_q;
  word_t     count_q;
  logic      halt_q;
  logic      timeout_q;

  logic imem_c;
  logic pc_en_c;
  logic capture_c;
  logic retire_c;
  logic expire_c;
  logic timeout_c;

`ifdef REQUEST_TIMEOUT_EN
  req_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RST),
    .start    (capture_c),
    .active   (state == DATA),
    .dhit     (bus.dhit),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Next state plus the combinational fetch request and PC enable.
  always_comb begin
    state_next = state;
    imem_c     = 1'b0;
    pc_en_c    = 1'b0;
    capture_c  = 1'b0;
    retire_c   = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      FETCH: begin
        imem_c = 1'b1;
        if (bus.ihit) begin
          if (bus.halt_ctrl) begin
            state_next = HALTED;
          end else if (bus.dREN_ctrl || bus.dWEN_ctrl) begin
            capture_c  = 1'b1;
            state_next = DATA;
          end else begin
            pc_en_c  = 1'b1;
            retire_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.dhit) begin
          pc_en_c    = 1'b1;
          retire_c   = 1'b1;
          state_next = FETCH;
        end else if (expire_c) begin
          timeout_c  = 1'b1;
          state_next = HALTED;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      req_q     <= '0;
      count_q   <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      // A load wins when both load and store are flagged.
      if (capture_c) begin
        req_q.addr <= word_align(bus.alu_result);
        req_q.data <= bus.store_data;
        req_q.ren  <= bus.dREN_ctrl;
        req_q.wen  <= bus.dWEN_ctrl && !bus.dREN_ctrl;
      end else if (state == DATA && state_next != DATA) begin
        req_q.ren <= 1'b0;
        req_q.wen <= 1'b0;
      end
      if (retire_c) begin
        count_q <= count_q + word_t'(1);
      end
      if (state_next == HALTED) begin
        halt_q <= 1'b1;
      end
      if (timeout_c) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.imemREN     = imem_c;
  assign bus.pc_en       = pc_en_c;
  assign bus.dmemREN     = req_q.ren;
  assign bus.dmemWEN     = req_q.wen;
  assign bus.dmemaddr    = req_q.addr;
  assign bus.dmemstore   = req_q.data;
  assign bus.halt        = halt_q;
  assign bus.instr_count = count_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: expected retires are queued as
// instructions are issued and compared whenever pc_en fires.
module tb_request_unit;
  import request_unit_pkg::*;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t data;
    word_t count;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  request_unit_if bus ();

`ifdef REQUEST_TIMEOUT_EN
  localparam int unsigned TMO = 8;
  request_unit #(.TIMEOUT_CYCLES(TMO)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`else
  request_unit dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  exp_t  sb[$];
  word_t model_count;
  int    n_pass   = 0;
  int    n_checks = 0;
  int    req_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ihit       = 1'b0;
    bus.dhit       = 1'b0;
    bus.dREN_ctrl  = 1'b0;
    bus.dWEN_ctrl  = 1'b0;
    bus.halt_ctrl  = 1'b0;
    bus.alu_result = '0;
    bus.store_data = '0;
  endtask

  // Retire monitor: every pc_en must match the oldest outstanding instruction.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (bus.dmemREN || bus.dmemWEN) req_cycles++;
      if (bus.pc_en) begin
        check("retire_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("retire_count", bus.instr_count, e.count);
          check("retire_ren", 32'(bus.dmemREN), 32'(e.ren));
          check("retire_wen", 32'(bus.dmemWEN), 32'(e.wen));
          if (e.ren || e.wen) begin
            check("retire_addr", bus.dmemaddr, e.addr);
            check("retire_store", bus.dmemstore, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    next();
    next();
    RST = 1'b0;
    model_count = '0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge CLK);
    check({tag, "_imemREN"}, 32'(bus.imemREN), 32'd1);
    check({tag, "_dmemREN"}, 32'(bus.dmemREN), 32'd0);
    check({tag, "_dmemWEN"}, 32'(bus.dmemWEN), 32'd0);
    check({tag, "_dmemaddr"}, bus.dmemaddr, 32'd0);
    check({tag, "_dmemstore"}, bus.dmemstore, 32'd0);
    check({tag, "_halt"}, 32'(bus.halt), 32'd0);
    check({tag, "_count"}, bus.instr_count, 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
    check({tag, "_pc_en"}, 32'(bus.pc_en), 32'd0);
    next();
  endtask

  // ALU-type instruction; a stray dhit in FETCH must be ignored.
  task automatic alu_instr();
    bus.ihit       = 1'b1;
    bus.dREN_ctrl  = 1'b0;
    bus.dWEN_ctrl  = 1'b0;
    bus.halt_ctrl  = 1'b0;
    bus.dhit       = 1'($urandom_range(0, 1));
    bus.alu_result = $urandom;
    sb.push_back('{ren: 1'b0, wen: 1'b0, addr: '0, data: '0, count: model_count});
    model_count++;
    next();
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
  endtask

  // Load/store with dhit on DATA cycle 'lat' (1 = first DATA cycle).
  task automatic mem_instr(input logic rd, input logic wr, input word_t addr,
                           input word_t data, input int lat);
    int c0;
    logic wen_exp;
    wen_exp        = wr && !rd;
    bus.ihit       = 1'b1;
    bus.dhit       = 1'b0;
    bus.halt_ctrl  = 1'b0;
    bus.dREN_ctrl  = rd;
    bus.dWEN_ctrl  = wr;
    bus.alu_result = addr;
    bus.store_data = data;
    sb.push_back('{ren: rd, wen: wen_exp, addr: addr & 32'hFFFF_FFFC, data: data,
                   count: model_count});
    model_count++;
    c0 = req_cycles;
    next();
    bus.dREN_ctrl  = 1'b0;
    bus.dWEN_ctrl  = 1'b0;
    bus.alu_result = $urandom;
    bus.store_data = $urandom;
    for (int i = 1; i <= lat; i++) begin
      bus.dhit      = (i == lat);
      bus.ihit      = (i == lat) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.halt_ctrl = (i == lat) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 1) begin
        @(negedge CLK);
        check("data_imemREN", 32'(bus.imemREN), 32'd0);
        check("data_ren", 32'(bus.dmemREN), 32'(rd));
        check("data_wen", 32'(bus.dmemWEN), 32'(wen_exp));
        check("data_addr", bus.dmemaddr, addr & 32'hFFFF_FFFC);
      end
      next();
    end
    bus.dhit      = 1'b0;
    bus.ihit      = 1'b0;
    bus.halt_ctrl = 1'b0;
    @(negedge CLK);
    check("req_cycles", 32'(req_cycles - c0), 32'(lat));
    check("after_imemREN", 32'(bus.imemREN), 32'd1);
    check("after_timeout", 32'(bus.timeout_err), 32'd0);
    check("after_count", bus.instr_count, model_count);
    next();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_reset_state("reset");

    repeat (3) alu_instr();
    @(negedge CLK);
    check("alu_count", bus.instr_count, 32'd3);
    check("alu_no_ren", 32'(bus.dmemREN), 32'd0);
    next();

    mem_instr(1'b1, 1'b0, 32'h0000_1007, 32'h1234_5678, 4);
    mem_instr(1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1);
    @(negedge CLK);
    check("store_data_held", bus.dmemstore, 32'hDEAD_BEEF);
    next();
    mem_instr(1'b1, 1'b1, 32'h0000_3002, 32'hCAFE_F00D, 2);
`ifndef REQUEST_TIMEOUT_EN
    mem_instr(1'b1, 1'b0, 32'h0000_4003, 32'h0, 20);
`endif

    for (int k = 0; k < 8; k++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) alu_instr();
      else mem_instr(1'(sel & 1), 1'(sel >> 1), $urandom, $urandom,
                     int'($urandom_range(1, 5)));
    end

    // HALT beats a simultaneous load and holds until reset.
    bus.ihit      = 1'b1;
    bus.halt_ctrl = 1'b1;
    bus.dREN_ctrl = 1'b1;
    next();
    idle_inputs();
    @(negedge CLK);
    check("halt_set", 32'(bus.halt), 32'd1);
    check("halt_no_ren", 32'(bus.dmemREN), 32'd0);
    check("halt_imemREN", 32'(bus.imemREN), 32'd0);
    next();
    repeat (6) begin
      bus.ihit      = 1'b1;
      bus.dhit      = 1'b1;
      bus.dREN_ctrl = 1'($urandom_range(0, 1));
      next();
    end
    idle_inputs();
    @(negedge CLK);
    check("halt_held", 32'(bus.halt), 32'd1);
    check("halt_count", bus.instr_count, model_count);
    check("halt_no_wen", 32'(bus.dmemWEN), 32'd0);
    next();

    do_reset();
    check_reset_state("rst_halt");

    // Reset while a load is outstanding drops it with no retire.
    alu_instr();
    bus.ihit       = 1'b1;
    bus.dREN_ctrl  = 1'b1;
    bus.alu_result = 32'h0000_5555;
    next();
    idle_inputs();
    next();
    @(negedge CLK);
    check("pre_rst_ren", 32'(bus.dmemREN), 32'd1);
    RST = 1'b1;
    next();
    RST = 1'b0;
    model_count = '0;
    check_reset_state("rst_data");

    // Counter wrap from all ones.
    @(negedge CLK);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    model_count = 32'hFFFF_FFFF;
    next();
    alu_instr();
    @(negedge CLK);
    check("wrap_count", bus.instr_count, model_count);
    next();

`ifdef REQUEST_TIMEOUT_EN
    do_reset();
    bus.ihit       = 1'b1;
    bus.dREN_ctrl  = 1'b1;
    bus.alu_result = 32'h0000_6000;
    next();
    idle_inputs();
    repeat (TMO - 1) next();
    @(negedge CLK);
    check("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
    check("tmo_ren_held", 32'(bus.dmemREN), 32'd1);
    next();
    @(negedge CLK);
    check("tmo_err", 32'(bus.timeout_err), 32'd1);
    check("tmo_halt", 32'(bus.halt), 32'd1);
    check("tmo_ren_drop", 32'(bus.dmemREN), 32'd0);
    check("tmo_count", bus.instr_count, 32'd0);
    next();
    do_reset();
    mem_instr(1'b1, 1'b0, 32'h0000_7004, 32'h0, int'(TMO));
    @(negedge CLK);
    check("tmo_edge_halt", 32'(bus.halt), 32'd0);
    next();
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
